// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: 2-way set-associative cache controller with LRU replacement,
// dirty-line write-back and 4-beat line refill from a 32-bit secondary memory.
module sa_cache_ctrl #(
    parameter int WAYS  = 2,
    parameter int SETS  = 1024,
    parameter int BEATS = 4,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] cpu_addr,
    input  logic [31:0] cpu_data,
    input  logic        cpu_rw,
    input  logic        cpu_valid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_stopped,
    output logic [19:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    output logic        mem_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int IW = $clog2(SETS);
    localparam int BW = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

    state_t            state, state_nx;
    logic [19:0]       req_addr;
    logic [31:0]       req_data;
    logic              req_rw;
    logic [BW-1:0]     beat;
    logic              victim;
    logic [SETS-1:0]   valid [WAYS];
    logic [SETS-1:0]   dirty [WAYS];
    logic [SETS-1:0]   lru   [WAYS];
    logic [TAG_W-1:0]  tags  [WAYS][SETS];
    logic [31:0]       data  [WAYS][SETS][BEATS];

    logic [TAG_W-1:0]  req_tag;
    logic [IW-1:0]     idx;
    logic [BW-1:0]     word;
    logic              hit0, hit1, hit, hw, vict_nx, last;

    assign req_tag = req_addr[19 -: TAG_W];
    assign idx     = req_addr[BW +: IW];
    assign word    = req_addr[BW-1:0];
    assign hit0    = valid[0][idx] && tags[0][idx] == req_tag;
    assign hit1    = valid[1][idx] && tags[1][idx] == req_tag;
    assign hit     = hit0 || hit1;
    assign hw      = !hit0;
    assign last    = beat == BW'(BEATS - 1);
    // first invalid way wins (way0 first); otherwise the LRU way, ties go to way0
    assign vict_nx = !valid[0][idx] ? 1'b0 :
                     !valid[1][idx] ? 1'b1 : (lru[1][idx] && !lru[0][idx]);

    assign cpu_stopped = state == WRITE_BACK || state == ALLOCATE;
    assign cpu_rdata   = (cpu_ready && !req_rw) ? data[hw][idx][word] : '0;

    always_comb begin
        state_nx  = state;
        cpu_ready = 1'b0;
        mem_valid = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: state_nx = cpu_valid ? COMPARE : IDLE;
            COMPARE: begin
                cpu_ready = hit;
                state_nx  = hit ? IDLE :
                            (valid[vict_nx][idx] && dirty[vict_nx][idx]) ? WRITE_BACK : ALLOCATE;
            end
            WRITE_BACK: begin
                mem_valid = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = {tags[victim][idx], idx, beat};
                mem_wdata = data[victim][idx][beat];
                state_nx  = (mem_ready && last) ? ALLOCATE : WRITE_BACK;
            end
            ALLOCATE: begin
                mem_valid = 1'b1;
                mem_addr  = {req_tag, idx, beat};
                state_nx  = (mem_ready && last) ? COMPARE : ALLOCATE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat     <= '0;
            victim   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            req_rw   <= 1'b0;
            for (int i = 0; i < WAYS; i++) begin
                valid[i] <= '0;
                dirty[i] <= '0;
                lru[i]   <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == IDLE && cpu_valid) begin
                req_addr <= cpu_addr;
                req_data <= cpu_data;
                req_rw   <= cpu_rw;
            end
            if (state == COMPARE && hit) begin
                lru[hw][idx]  <= 1'b0;
                lru[!hw][idx] <= 1'b1;
                if (req_rw) dirty[hw][idx] <= 1'b1;
            end
            if (state == COMPARE && !hit) victim <= vict_nx;
            if (cpu_stopped && mem_ready) beat <= beat + BW'(1);
            // the line only becomes visible once its final beat has landed
            if (state == ALLOCATE && mem_ready && last) begin
                valid[victim][idx] <= 1'b1;
                dirty[victim][idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && req_rw) data[hw][idx][word] <= req_data;
        if (state == ALLOCATE && mem_ready) data[victim][idx][beat] <= mem_rdata;
        if (state == ALLOCATE && mem_ready && last) tags[victim][idx] <= req_tag;
    end
endmodule

// File: tb/tb_sa_cache_ctrl.sv
// tb_sa_cache_ctrl: scoreboard bench for sa_cache_ctrl; expected CPU responses and
// memory beats are queued by the stimulus and popped by independent monitors.
module tb_sa_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] cpu_addr = '0;
    logic [31:0] cpu_data = '0;
    logic        cpu_rw = 1'b0;
    logic        cpu_valid = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_stopped;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic        mem_valid;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    sa_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_rw(cpu_rw), .cpu_valid(cpu_valid),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stopped(cpu_stopped),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic rd; logic [31:0] d;} cpu_exp_t;
    typedef struct packed {logic [19:0] a; logic w; logic [31:0] d;} mem_exp_t;

    cpu_exp_t    cpu_q[$];
    mem_exp_t    mem_q[$];
    logic [31:0] mem_model [logic [19:0]];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_grant = 0;
    int          hold_req = 0;
    int          held = 0;
    logic [19:0] hold_addr = 20'h03002;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [19:0] a);
        return mem_model.exists(a) ? mem_model[a] : (32'hC0DE0000 | {12'h0, a});
    endfunction

    task automatic exp_refill(input logic [19:0] base);
        for (int i = 0; i < 4; i++) mem_q.push_back({base + 20'(i), 1'b0, 32'h0});
    endtask

    task automatic exp_cpu(input logic rd, input logic [31:0] d);
        cpu_q.push_back({rd, d});
    endtask

    // CPU-side monitor
    always @(negedge clk) begin
        if (cpu_ready) begin
            if (cpu_q.size() == 0) check("cpu_unexpected_ready", 32'd1, 32'd0);
            else begin
                cpu_exp_t e;
                e = cpu_q.pop_front();
                if (e.rd) check("cpu_rdata", cpu_rdata, e.d);
            end
        end
    end

    // memory responder and beat monitor
    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (mem_valid) begin
            if (held < hold_req && !mem_rw && mem_addr[1:0] == 2'd2) begin
                held++;
                check("stall_addr", {12'h0, mem_addr}, {12'h0, hold_addr});
                check("stall_stopped", {31'h0, cpu_stopped}, 32'd1);
            end else begin
                mem_ready = 1'b1;
                n_grant++;
                mem_rdata = rd_mem(mem_addr);
                if (mem_rw) mem_model[mem_addr] = mem_wdata;
                if (mem_q.size() == 0) check("mem_unexpected_beat", {12'h0, mem_addr}, 32'hFFFFFFFF);
                else begin
                    mem_exp_t m;
                    m = mem_q.pop_front();
                    check("mem_addr", {12'h0, mem_addr}, {12'h0, m.a});
                    check("mem_rw", {31'h0, mem_rw}, {31'h0, m.w});
                    if (m.w) check("mem_wdata", mem_wdata, m.d);
                end
            end
        end
    end

    task automatic issue(input logic [19:0] a, input logic [31:0] d, input logic rw);
        @(negedge clk);
        cpu_addr  = a;
        cpu_data  = d;
        cpu_rw    = rw;
        cpu_valid = 1'b1;
        @(negedge clk);
        cpu_valid = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!cpu_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!cpu_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int g;
        logic found;
        mem_model[20'h00000] = 32'h11;
        mem_model[20'h00001] = 32'h22;
        mem_model[20'h00002] = 32'h33;
        mem_model[20'h00003] = 32'h44;
        repeat (2) @(negedge clk);
        check("rst_cpu_ready", {31'h0, cpu_ready}, 32'd0);
        check("rst_cpu_stopped", {31'h0, cpu_stopped}, 32'd0);
        check("rst_mem_valid", {31'h0, mem_valid}, 32'd0);
        check("rst_mem_rw", {31'h0, mem_rw}, 32'd0);
        check("rst_mem_addr", {12'h0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        rst = 1'b0;
        // cold miss: refill only
        exp_refill(20'h00000);
        exp_cpu(1'b1, 32'h11);
        issue(20'h00000, 32'h0, 1'b0);
        wait_ready(cyc);
        check("miss_latency", cyc, 32'd5);
        // hit right after
        g = n_grant;
        exp_cpu(1'b1, 32'h33);
        issue(20'h00002, 32'h0, 1'b0);
        wait_ready(cyc);
        check("hit_latency", cyc, 32'd0);
        check("hit_mem_valid", {31'h0, mem_valid}, 32'd0);
        check("hit_no_beats", n_grant, g);
        // write miss into way1
        exp_refill(20'h01000);
        exp_cpu(1'b0, 32'h0);
        issue(20'h01000, 32'hDEADBEEF, 1'b1);
        wait_ready(cyc);
        check("wmiss_latency", cyc, 32'd5);
        // set full: way0 is LRU and clean
        exp_refill(20'h02000);
        exp_cpu(1'b1, 32'hC0DE2000);
        issue(20'h02000, 32'h0, 1'b0);
        wait_ready(cyc);
        check("clean_victim_latency", cyc, 32'd5);
        // dirty way1 victim with a 5-cycle refill stall on beat 2
        mem_q.push_back({20'h01000, 1'b1, 32'hDEADBEEF});
        mem_q.push_back({20'h01001, 1'b1, 32'hC0DE1001});
        mem_q.push_back({20'h01002, 1'b1, 32'hC0DE1002});
        mem_q.push_back({20'h01003, 1'b1, 32'hC0DE1003});
        exp_refill(20'h03000);
        exp_cpu(1'b1, 32'hC0DE3000);
        hold_req = 5;
        issue(20'h03000, 32'h0, 1'b0);
        wait_ready(cyc);
        check("wb_stall_latency", cyc, 32'd14);
        check("stall_cycles", held, 32'd5);
        // dirty both ways, then force a write-back and reset on beat 2
        exp_cpu(1'b0, 32'h0);
        issue(20'h03001, 32'hCAFEF00D, 1'b1);
        wait_ready(cyc);
        check("whit1_latency", cyc, 32'd0);
        exp_cpu(1'b0, 32'h0);
        issue(20'h02003, 32'h0BADF00D, 1'b1);
        wait_ready(cyc);
        check("whit0_latency", cyc, 32'd0);
        mem_q.push_back({20'h03000, 1'b1, 32'hC0DE3000});
        mem_q.push_back({20'h03001, 1'b1, 32'hCAFEF00D});
        mem_q.push_back({20'h03002, 1'b1, 32'hC0DE3002});
        issue(20'h05000, 32'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (mem_valid && mem_rw && mem_addr[1:0] == 2'd2) found = 1'b1;
        end
        check("wb_beat2_seen", {31'h0, found}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_valid", {31'h0, mem_valid}, 32'd0);
        check("abort_cpu_stopped", {31'h0, cpu_stopped}, 32'd0);
        check("abort_mem_addr", {12'h0, mem_addr}, 32'd0);
        rst = 1'b0;
        // valid bits were cleared: same address misses, no write-back
        exp_refill(20'h05000);
        exp_cpu(1'b1, 32'hC0DE5000);
        issue(20'h05000, 32'h0, 1'b0);
        wait_ready(cyc);
        check("post_rst_miss_latency", cyc, 32'd5);
        // cpu_valid held high with a changing address during refill
        exp_refill(20'h06000);
        exp_cpu(1'b1, 32'hC0DE6001);
        @(negedge clk);
        cpu_addr  = 20'h06001;
        cpu_rw    = 1'b0;
        cpu_valid = 1'b1;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_ready) break;
            cyc++;
            cpu_addr = 20'h07002;
            cpu_rw   = 1'b1;
            cpu_data = 32'h5555AAAA;
        end
        check("held_valid_ready", {31'h0, cpu_ready}, 32'd1);
        check("held_valid_latency", cyc, 32'd5);
        cpu_valid = 1'b0;
        g = n_grant;
        repeat (3) @(negedge clk);
        check("idle_mem_valid", {31'h0, mem_valid}, 32'd0);
        check("idle_no_beats", n_grant, g);
        check("cpu_q_empty", cpu_q.size(), 32'd0);
        check("mem_q_empty", mem_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
